rom_tdm_nch: RTL and testbench

ROM_TDM_NCH -- requirements
Module: rom_tdm_nch

---
 rtl/rom_pkg.sv | 31 +++
 rtl/rr_arbiter.sv | 53 +++++
 rtl/rom_tdm_nch.sv | 136 +++++++++++++
 tb/tb_rom_tdm_nch.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rom_pkg.sv
// rom_pkg: definitions shared by the time-division-multiplexed ROM and its
// round-robin arbiter.
//   fold_mode_e   : storage mode (plain table or quarter-wave folded table)
//   DEF_ADDR_W/DEF_DATA_W : default client address / data slice widths
//   clog2()       : index width for a channel count (never less than 1)
//   slice_lo()    : low bit of slice k on a flat bus of w-bit slices
package rom_pkg;

  typedef enum logic {
    FOLD_NONE    = 1'b0,
    FOLD_QUARTER = 1'b1
  } fold_mode_e;

  localparam int DEF_ADDR_W = 9;
  localparam int DEF_DATA_W = 8;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < value) r = r + 1;
    end
    if (r == 0) r = 1;
    return r;
  endfunction

  function automatic int slice_lo(input int k, input int w);
    return k * w;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin arbiter granting one requester per enabled cycle.
//   i_clk, i_rst_n : clock, synchronous active-low reset
//   i_en           : low suppresses grants and freezes the pointer
//   i_req          : request vector
//   o_grant        : one-hot grant (combinational)
//   o_idx, o_vld   : index of the granted requester and grant-valid flag
// The pointer holds the last granted index; the search starts one past it.
// Reset loads NUM_CH-1 so channel 0 has the highest priority afterwards.
module rr_arbiter
  import rom_pkg::*;
#(
  parameter int NUM_CH = 8,
  parameter int IDX_W  = clog2(NUM_CH)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_en,
  input  logic [NUM_CH-1:0] i_req,
  output logic [NUM_CH-1:0] o_grant,
  output logic [IDX_W-1:0]  o_idx,
  output logic              o_vld
);

  logic [IDX_W-1:0] last_q;
  logic [IDX_W-1:0] last_d;
  int               cand;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_vld   = 1'b0;
    last_d  = last_q;
    cand    = 0;
    if (i_en) begin
      for (int off = 1; off <= NUM_CH; off++) begin
        cand = int'(last_q) + off;
        if (cand >= NUM_CH) cand = cand - NUM_CH;
        if (!o_vld && i_req[cand]) begin
          o_vld         = 1'b1;
          o_idx         = IDX_W'(cand);
          o_grant[cand] = 1'b1;
        end
      end
      if (o_vld) last_d = o_idx;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) last_q <= IDX_W'(NUM_CH - 1);
    else          last_q <= last_d;
  end

endmodule

// File: rtl/rom_tdm_nch.sv
// rom_tdm_nch: one registered ROM shared by NUM_CH clients, one read/cycle.
//   i_clk, i_rst_n : clock, synchronous active-low reset
//   i_en           : grant enable (low stalls new reads only)
//   i_req, i_addr  : per-channel request pulse and flat address bus
//   i_clr_ovr      : clears all sticky overrun flags
//   o_data         : flat per-channel result registers
//   o_valid        : per-channel pulse when its o_data slice updates
//   o_overrun      : sticky flag, request arrived while one was still waiting
// Flow: request captured (pending + address), arbiter grants and the ROM
// read is issued, result folded and written into the channel slice.
module rom_tdm_nch
  import rom_pkg::*;
#(
  parameter int    NUM_CH       = 8,
  parameter int    ADDR_WIDTH   = DEF_ADDR_W,
  parameter int    DATA_WIDTH   = DEF_DATA_W,
  parameter string LOAD_PATH    = "",
  parameter int    QUARTER_WAVE = 0
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_en,
  input  logic [NUM_CH-1:0]            i_req,
  input  logic [NUM_CH*ADDR_WIDTH-1:0] i_addr,
  input  logic                         i_clr_ovr,
  output logic [NUM_CH*DATA_WIDTH-1:0] o_data,
  output logic [NUM_CH-1:0]            o_valid,
  output logic [NUM_CH-1:0]            o_overrun
);

  localparam fold_mode_e FOLD = (QUARTER_WAVE != 0) ? FOLD_QUARTER : FOLD_NONE;
  localparam int MEM_AW    = (FOLD == FOLD_QUARTER) ? ADDR_WIDTH - 2 : ADDR_WIDTH;
  localparam int MEM_DEPTH = 1 << MEM_AW;
  localparam int CH_W      = clog2(NUM_CH);

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  // Offset-binary negation of the stored quarter-wave sample.
  function automatic logic [DATA_WIDTH-1:0] fold_out(input logic [DATA_WIDTH-1:0] w,
                                                     input logic neg);
    return neg ? ~w : w;
  endfunction

  logic [NUM_CH-1:0]            pend_q, pend_d;
  logic [NUM_CH-1:0]            ovr_q, ovr_d;
  logic [NUM_CH-1:0]            vld_q, vld_d;
  logic [NUM_CH*DATA_WIDTH-1:0] data_q, data_d;
  logic [ADDR_WIDTH-1:0]        addr_q [NUM_CH];
  logic [ADDR_WIDTH-1:0]        addr_d [NUM_CH];

  logic                  rd_vld_q, rd_vld_d;
  logic [CH_W-1:0]       rd_ch_q, rd_ch_d;
  logic                  rd_neg_q, rd_neg_d;
  logic [DATA_WIDTH-1:0] rd_word_q;

  logic [NUM_CH-1:0]     grant;
  logic [CH_W-1:0]       gnt_idx;
  logic                  gnt_vld;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [MEM_AW-1:0]     rd_idx;

  rr_arbiter #(
    .NUM_CH (NUM_CH),
    .IDX_W  (CH_W)
  ) u_arb (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_en    (i_en),
    .i_req   (pend_q),
    .o_grant (grant),
    .o_idx   (gnt_idx),
    .o_vld   (gnt_vld)
  );

  // Quarter-wave fold: second quadrant mirrors the index, upper half
  // negates the sample (negation is applied after the read).
  always_comb begin
    sel_addr = addr_q[gnt_idx];
    rd_neg_d = 1'b0;
    if (FOLD == FOLD_QUARTER) begin
      rd_idx   = sel_addr[ADDR_WIDTH-2] ? ~sel_addr[MEM_AW-1:0] : sel_addr[MEM_AW-1:0];
      rd_neg_d = sel_addr[ADDR_WIDTH-1];
    end else begin
      rd_idx = sel_addr[MEM_AW-1:0];
    end
  end

  always_comb begin
    for (int k = 0; k < NUM_CH; k++) begin
      addr_d[k] = addr_q[k];
      if (i_req[k]) addr_d[k] = i_addr[slice_lo(k, ADDR_WIDTH) +: ADDR_WIDTH];
    end
    // A request coinciding with its own grant is a fresh request, not an overrun.
    pend_d   = (pend_q & ~grant) | i_req;
    ovr_d    = (ovr_q & {NUM_CH{~i_clr_ovr}}) | (i_req & pend_q & ~grant);
    rd_vld_d = gnt_vld;
    rd_ch_d  = gnt_idx;
    vld_d    = '0;
    data_d   = data_q;
    if (rd_vld_q) begin
      vld_d[rd_ch_q] = 1'b1;
      data_d[slice_lo(int'(rd_ch_q), DATA_WIDTH) +: DATA_WIDTH] = fold_out(rd_word_q, rd_neg_q);
    end
  end

  // Control and result registers (capture, issue and output stages).
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      pend_q   <= '0;
      ovr_q    <= '0;
      vld_q    <= '0;
      data_q   <= '0;
      rd_vld_q <= 1'b0;
    end else begin
      pend_q   <= pend_d;
      ovr_q    <= ovr_d;
      vld_q    <= vld_d;
      data_q   <= data_d;
      rd_vld_q <= rd_vld_d;
    end
  end

  // Capture stage: per-channel address registers.
  // Issue stage: ROM read plus channel/negate tags travelling with it.
  always_ff @(posedge i_clk) begin
    for (int k = 0; k < NUM_CH; k++) addr_q[k] <= addr_d[k];
    rd_ch_q  <= rd_ch_d;
    rd_neg_q <= rd_neg_d;
    if (gnt_vld) rd_word_q <= mem[rd_idx];
  end

  assign o_data    = data_q;
  assign o_valid   = vld_q;
  assign o_overrun = ovr_q;

endmodule

// File: tb/tb_rom_tdm_nch.sv
module tb_rom_tdm_nch;

  localparam int NCH = 8;
  localparam int AW  = 9;
  localparam int DW  = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n, en, clr;
  logic [NCH-1:0]    req;
  logic [NCH*AW-1:0] addr;
  logic [NCH*DW-1:0] odata;
  logic [NCH-1:0]    ovalid, oovr;

  logic        q_en, q_clr;
  logic [1:0]  q_req;
  logic [2*AW-1:0] q_addr;
  logic [2*DW-1:0] q_odata;
  logic [1:0]  q_ovalid, q_oovr;

  rom_tdm_nch #(.NUM_CH(NCH), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .QUARTER_WAVE(0)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_req(req), .i_addr(addr),
    .i_clr_ovr(clr), .o_data(odata), .o_valid(ovalid), .o_overrun(oovr));

  rom_tdm_nch #(.NUM_CH(2), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .QUARTER_WAVE(1)) dut_q (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(q_en), .i_req(q_req), .i_addr(q_addr),
    .i_clr_ovr(q_clr), .o_data(q_odata), .o_valid(q_ovalid), .o_overrun(q_oovr));

  typedef struct {
    int        ch;
    logic [7:0] data;
    int        e0;
    int        lat;
  } sb_t;

  typedef struct {
    int        ch;
    int        a;
    logic [7:0] exp;
  } vec_t;

  typedef struct {
    int        a;
    logic [7:0] exp;
  } qvec_t;

  sb_t  sb_q[$];
  logic [7:0] img  [512];
  logic [7:0] qimg [128];
  logic [NCH*DW-1:0] shadow;
  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  logic rst_seen = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int ch, input logic [7:0] d, input int lat);
    sb_t e;
    e.ch = ch; e.data = d; e.e0 = cyc + 1; e.lat = lat;
    sb_q.push_back(e);
  endtask

  task automatic drive_req(input int ch, input int a, input int lat);
    req[ch] = 1'b1;
    addr[ch*AW +: AW] = 9'(a);
    push(ch, img[a], lat);
  endtask

  // Last-wins: the waiting entry of this channel now expects the new address.
  task automatic retarget(input int ch, input int a);
    bit done;
    done = 1'b0;
    req[ch] = 1'b1;
    addr[ch*AW +: AW] = 9'(a);
    for (int i = sb_q.size() - 1; i >= 0; i--) begin
      if (!done && sb_q[i].ch == ch) begin
        sb_q[i].data = img[a];
        sb_q[i].lat  = -1;
        done = 1'b1;
      end
    end
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d results outstanding, required 0", sb_q.size());
      sb_q.delete();
    end
    tick();
    tick();
  endtask

  always @(posedge clk) begin
    cyc = cyc + 1;
    rst_seen = rst_n;
  end

  always @(negedge clk) begin
    if (!rst_seen) begin
      sb_q.delete();
      shadow = '0;
      chk("rst_valid", 64'(ovalid), 64'(0));
      chk("rst_data", 64'(odata), 64'(0));
      chk("rst_overrun", 64'(oovr), 64'(0));
    end else begin
      for (int k = 0; k < NCH; k++) begin
        if (ovalid[k]) begin
          int idx;
          idx = -1;
          for (int i = 0; i < sb_q.size(); i++)
            if (idx < 0 && sb_q[i].ch == k) idx = i;
          if (idx < 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_valid: ch%0d pulsed, required no pulse", k);
          end else begin
            chk($sformatf("data_ch%0d", k), 64'(odata[k*DW +: DW]), 64'(sb_q[idx].data));
            if (sb_q[idx].lat >= 0)
              chk($sformatf("latency_ch%0d", k), 64'(cyc - sb_q[idx].e0), 64'(sb_q[idx].lat));
            shadow[k*DW +: DW] = sb_q[idx].data;
            sb_q.delete(idx);
          end
        end
      end
      chk("hold_data", 64'(odata), 64'(shadow));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t  tbl [8];
    qvec_t qtbl [7];
    int n;

    for (int i = 0; i < 512; i++) img[i] = 8'((i * 37 + 11) ^ (i >> 3));
    img[5] = 8'h3C;
    for (int i = 0; i < 128; i++) qimg[i] = 8'(i * 13 + 100);
    qimg[8'h10] = 8'h90;
    qimg[8'h6F] = 8'h90;
    for (int i = 0; i < 512; i++) dut.mem[i] = img[i];
    for (int i = 0; i < 128; i++) dut_q.mem[i] = qimg[i];

    tbl[0] = '{2, 5, 8'h3C};
    tbl[1] = '{0, 0, img[0]};
    tbl[2] = '{7, 511, img[511]};
    tbl[3] = '{1, 256, img[256]};
    tbl[4] = '{3, 255, img[255]};
    tbl[5] = '{4, 170, img[170]};
    tbl[6] = '{5, 85, img[85]};
    tbl[7] = '{6, 300, img[300]};

    qtbl[0] = '{'h010, 8'h90};
    qtbl[1] = '{'h06F, 8'h90};
    qtbl[2] = '{'h0EF, 8'h90};
    qtbl[3] = '{'h0F0, qimg[8'h0F]};
    qtbl[4] = '{'h110, 8'h6F};
    qtbl[5] = '{'h1F0, ~qimg[8'h0F]};
    qtbl[6] = '{'h070, qimg[8'h70]};

    rst_n = 1'b0; en = 1'b1; clr = 1'b0; req = '0; addr = '0;
    q_en = 1'b1; q_clr = 1'b0; q_req = '0; q_addr = '0;
    tick(); tick(); tick();
    rst_n = 1'b1;
    tick();

    // All channels at once: grants 0..7, latencies 2..9.
    for (int k = 0; k < NCH; k++) drive_req(k, 10 * k + 1, 2 + k);
    tick();
    req = '0;
    wait_drain(20);

    // Single requests from the table, each at minimum latency.
    for (int i = 0; i < 8; i++) begin
      drive_req(tbl[i].ch, tbl[i].a, 2);
      sb_q[sb_q.size() - 1].data = tbl[i].exp;
      tick();
      req = '0;
      wait_drain(10);
    end

    // Re-request at the grant edge: both results, no overrun.
    drive_req(4, 20, 2);
    tick();
    drive_req(4, 21, 2);
    tick();
    req = '0;
    wait_drain(10);
    chk("ovr_at_grant", 64'(oovr), 64'(0));

    // Overrun while stalled, last address wins, then clear.
    en = 1'b0;
    drive_req(3, 40, -1);
    tick();
    retarget(3, 41);
    tick();
    req = '0;
    tick(); tick(); tick();
    chk("ovr_set", 64'(oovr), 64'h08);
    chk("stalled_outstanding", 64'(sb_q.size()), 64'(1));
    en = 1'b1;
    wait_drain(10);
    chk("ovr_sticky", 64'(oovr), 64'h08);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("ovr_cleared", 64'(oovr), 64'(0));

    // Clear and a new overrun on the same edge leave the flag set.
    en = 1'b0;
    drive_req(5, 50, -1);
    tick();
    retarget(5, 51);
    clr = 1'b1;
    tick();
    req = '0;
    clr = 1'b0;
    chk("ovr_clr_collide", 64'(oovr), 64'h20);
    en = 1'b1;
    wait_drain(10);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("ovr_cleared2", 64'(oovr), 64'(0));

    // Enable drops after issue: issued read completes, new request waits.
    drive_req(6, 60, 2);
    tick();
    req = '0;
    tick();
    en = 1'b0;
    drive_req(0, 70, -1);
    tick();
    req = '0;
    tick(); tick(); tick();
    chk("en_low_outstanding", 64'(sb_q.size()), 64'(1));
    en = 1'b1;
    wait_drain(10);

    // Reset one cycle after ch1 is granted; request during reset ignored.
    drive_req(1, 80, 2);
    tick();
    req = '0;
    tick();
    rst_n = 1'b0;
    req[7] = 1'b1;
    addr[7*AW +: AW] = 9'd90;
    tick();
    req = '0;
    tick();
    rst_n = 1'b1;
    tick();
    drive_req(0, 100, 2);
    drive_req(1, 101, 3);
    tick();
    req = '0;
    wait_drain(10);

    // Quarter-wave folded instance.
    for (int i = 0; i < 7; i++) begin
      int ch;
      ch = i % 2;
      q_req[ch] = 1'b1;
      q_addr[ch*AW +: AW] = 9'(qtbl[i].a);
      tick();
      q_req = '0;
      n = 0;
      while (!q_ovalid[ch] && n < 8) begin
        tick();
        n++;
      end
      chk($sformatf("qw_latency_%0h", qtbl[i].a), 64'(n), 64'(2));
      chk($sformatf("qw_data_%0h", qtbl[i].a), 64'(q_odata[ch*DW +: DW]), 64'(qtbl[i].exp));
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
